// File: rtl/arp_udp_responder.sv
// ARP/UDP reply engine: answers ARP requests for MY_IP and echoes UDP payloads received
// on PORT_BASE..PORT_BASE+NUM_PORTS-1 through one payload buffer and one TX request port.
module arp_udp_responder #(
  parameter logic [31:0] MY_IP     = 32'hC0A8010A,
  parameter logic [15:0] PORT_BASE = 16'd5000,
  parameter int          NUM_PORTS = 2,
  parameter int          BUF_DEPTH = 256
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        is_arp,
  input  logic        is_ipv4,
  input  logic        is_udp,
  input  logic [15:0] arp_opcode,
  input  logic [31:0] arp_target_ip,
  input  logic [31:0] rx_dst_ip,
  input  logic [47:0] rx_src_mac,
  input  logic [31:0] rx_src_ip,
  input  logic [15:0] udp_src_port,
  input  logic [15:0] udp_dst_port,
  input  logic [7:0]  udp_payload,
  input  logic        udp_payload_valid,
  input  logic        udp_payload_last,
  input  logic        frame_done,
  input  logic        frame_ok,
  output logic        arp_req,
  input  logic        arp_ack,
  output logic        udp_req,
  input  logic        udp_ack,
  output logic [47:0] tx_dst_mac,
  output logic [31:0] tx_dst_ip,
  output logic [15:0] tx_dst_port,
  output logic [15:0] tx_src_port,
  output logic [3:0]  tx_chan,
  output logic [15:0] tx_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [15:0] drop_cnt
);
  // state  | meaning
  // R_IDLE | waiting for payload (or end) of a qualifying UDP frame
  // R_CAP  | writing payload bytes into the buffer
  // R_DROP | frame rejected, waiting for frame_done to count it
  // T_IDLE | nothing to send
  // T_ARP  | ARP reply requested
  // T_UDP  | echo header requested
  // T_DATA | streaming the buffered payload

  localparam int          AW     = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH  = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0] ONE_W  = (AW+1)'(1);
  localparam logic [16:0] NPORTS = 17'(NUM_PORTS);

  typedef enum logic [1:0] {R_IDLE, R_CAP, R_DROP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ARP, T_UDP, T_DATA} tx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  tx_state_t   tx_state_q, tx_state_d;
  logic [AW:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0] len_q, len_d;
  logic        buf_full_q, buf_full_d;
  logic        arp_pend_q, arp_pend_d;
  logic [47:0] arp_mac_q, arp_mac_d;
  logic [31:0] arp_ip_q, arp_ip_d;
  logic [47:0] udp_mac_q, udp_mac_d;
  logic [31:0] udp_ip_q, udp_ip_d;
  logic [15:0] udp_sport_q, udp_sport_d;
  logic [15:0] udp_dport_q, udp_dport_d;
  logic [3:0]  chan_q, chan_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [7:0]  mem_q [BUF_DEPTH];

  logic [16:0] port_off;
  logic        arp_hit, udp_hit, mem_we, commit, drop, buf_free, arp_clr, rd_last;
  logic        unused_ok;

  // Payload length is tracked by byte count; the last flag is not needed.
  assign unused_ok = udp_payload_last;

  assign port_off = {1'b0, udp_dst_port} - {1'b0, PORT_BASE};
  assign udp_hit  = is_ipv4 & is_udp & (rx_dst_ip == MY_IP) & (port_off < NPORTS);
  assign arp_hit  = frame_done & frame_ok & is_arp & (arp_opcode == 16'd1) &
                    (arp_target_ip == MY_IP) & ~arp_pend_q;
  assign rd_last  = ({1'b0, rd_q} == (len_q - ONE_W));

  always_comb begin
    rx_state_d = rx_state_q;
    wr_cnt_d   = wr_cnt_q;
    mem_we     = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (udp_hit && frame_done) begin
          // zero-length frame: wr_cnt_q is 0 here, so a commit records len 0
          if (frame_ok && !buf_full_q) commit = 1'b1;
          else                         drop   = 1'b1;
        end else if (udp_hit && udp_payload_valid) begin
          if (buf_full_q) begin
            rx_state_d = R_DROP;
          end else begin
            mem_we     = 1'b1;
            wr_cnt_d   = ONE_W;
            rx_state_d = R_CAP;
          end
        end
      end
      R_CAP: begin
        if (frame_done) begin
          if (frame_ok) commit = 1'b1;
          else          drop   = 1'b1;
          wr_cnt_d   = '0;
          rx_state_d = R_IDLE;
        end else if (udp_payload_valid) begin
          if (wr_cnt_q == DEPTH) begin
            rx_state_d = R_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + ONE_W;
          end
        end
      end
      R_DROP: begin
        wr_cnt_d = '0;
        if (frame_done) begin
          drop       = 1'b1;
          rx_state_d = R_IDLE;
        end
      end
      default: begin
        wr_cnt_d   = '0;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    rd_d       = rd_q;
    buf_free   = 1'b0;
    arp_clr    = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (arp_pend_q)      tx_state_d = T_ARP;
        else if (buf_full_q) tx_state_d = T_UDP;
      end
      T_ARP: begin
        if (arp_ack) begin
          arp_clr    = 1'b1;
          tx_state_d = T_IDLE;
        end
      end
      T_UDP: begin
        if (udp_ack) begin
          rd_d = '0;
          if (len_q == '0) begin
            buf_free   = 1'b1;
            tx_state_d = T_IDLE;
          end else begin
            tx_state_d = T_DATA;
          end
        end
      end
      T_DATA: begin
        if (tx_ready) begin
          if (rd_last) begin
            buf_free   = 1'b1;
            tx_state_d = T_IDLE;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    buf_full_d  = buf_full_q;
    len_d       = len_q;
    udp_mac_d   = udp_mac_q;
    udp_ip_d    = udp_ip_q;
    udp_sport_d = udp_sport_q;
    udp_dport_d = udp_dport_q;
    chan_d      = chan_q;
    if (commit) begin
      buf_full_d  = 1'b1;
      len_d       = wr_cnt_q;
      udp_mac_d   = rx_src_mac;
      udp_ip_d    = rx_src_ip;
      udp_sport_d = udp_src_port;
      udp_dport_d = udp_dst_port;
      chan_d      = udp_dst_port[3:0] - PORT_BASE[3:0];
    end else if (buf_free) begin
      buf_full_d = 1'b0;
    end
    arp_pend_d = arp_pend_q;
    arp_mac_d  = arp_mac_q;
    arp_ip_d   = arp_ip_q;
    if (arp_hit) begin
      arp_pend_d = 1'b1;
      arp_mac_d  = rx_src_mac;
      arp_ip_d   = rx_src_ip;
    end else if (arp_clr) begin
      arp_pend_d = 1'b0;
    end
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_comb begin
    arp_req     = 1'b0;
    udp_req     = 1'b0;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    tx_data     = '0;
    tx_dst_mac  = '0;
    tx_dst_ip   = '0;
    tx_dst_port = '0;
    tx_src_port = '0;
    tx_chan     = '0;
    tx_len      = '0;
    case (tx_state_q)
      T_ARP: begin
        arp_req    = 1'b1;
        tx_dst_mac = arp_mac_q;
        tx_dst_ip  = arp_ip_q;
      end
      T_UDP, T_DATA: begin
        udp_req     = (tx_state_q == T_UDP);
        tx_dst_mac  = udp_mac_q;
        tx_dst_ip   = udp_ip_q;
        tx_dst_port = udp_sport_q;
        tx_src_port = udp_dport_q;
        tx_chan     = chan_q;
        tx_len      = 16'(len_q);
        if (tx_state_q == T_DATA) begin
          tx_valid = 1'b1;
          tx_data  = mem_q[rd_q];
          tx_last  = rd_last;
        end
      end
      default: ;
    endcase
  end

  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk50) begin
    if (mem_we) mem_q[wr_cnt_q[AW-1:0]] <= udp_payload;
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      rx_state_q  <= R_IDLE;
      tx_state_q  <= T_IDLE;
      wr_cnt_q    <= '0;
      rd_q        <= '0;
      len_q       <= '0;
      buf_full_q  <= 1'b0;
      arp_pend_q  <= 1'b0;
      arp_mac_q   <= '0;
      arp_ip_q    <= '0;
      udp_mac_q   <= '0;
      udp_ip_q    <= '0;
      udp_sport_q <= '0;
      udp_dport_q <= '0;
      chan_q      <= '0;
      drop_cnt_q  <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_q        <= rd_d;
      len_q       <= len_d;
      buf_full_q  <= buf_full_d;
      arp_pend_q  <= arp_pend_d;
      arp_mac_q   <= arp_mac_d;
      arp_ip_q    <= arp_ip_d;
      udp_mac_q   <= udp_mac_d;
      udp_ip_q    <= udp_ip_d;
      udp_sport_q <= udp_sport_d;
      udp_dport_q <= udp_dport_d;
      chan_q      <= chan_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_arp_udp_responder.sv
// Directed bench for arp_udp_responder: ARP replies, UDP echo, drops, arbitration, reset.
module tb_arp_udp_responder;
  localparam logic [31:0] MY = 32'hC0A8010A;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic        is_arp, is_ipv4, is_udp;
  logic [15:0] arp_opcode;
  logic [31:0] arp_target_ip, rx_dst_ip, rx_src_ip;
  logic [47:0] rx_src_mac;
  logic [15:0] udp_src_port, udp_dst_port;
  logic [7:0]  udp_payload;
  logic        udp_payload_valid, udp_payload_last, frame_done, frame_ok;
  logic        arp_req, arp_ack, udp_req, udp_ack;
  logic [47:0] tx_dst_mac;
  logic [31:0] tx_dst_ip;
  logic [15:0] tx_dst_port, tx_src_port, tx_len, drop_cnt;
  logic [3:0]  tx_chan;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, tx_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb [300];
  logic [7:0] eb [300];

  arp_udp_responder dut (
    .clk50(clk50), .rst_n(rst_n),
    .is_arp(is_arp), .is_ipv4(is_ipv4), .is_udp(is_udp),
    .arp_opcode(arp_opcode), .arp_target_ip(arp_target_ip),
    .rx_dst_ip(rx_dst_ip), .rx_src_mac(rx_src_mac), .rx_src_ip(rx_src_ip),
    .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port),
    .udp_payload(udp_payload), .udp_payload_valid(udp_payload_valid),
    .udp_payload_last(udp_payload_last),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .arp_req(arp_req), .arp_ack(arp_ack), .udp_req(udp_req), .udp_ack(udp_ack),
    .tx_dst_mac(tx_dst_mac), .tx_dst_ip(tx_dst_ip),
    .tx_dst_port(tx_dst_port), .tx_src_port(tx_src_port),
    .tx_chan(tx_chan), .tx_len(tx_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .drop_cnt(drop_cnt)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic clear_in();
    is_arp = 0; is_ipv4 = 0; is_udp = 0;
    arp_opcode = '0; arp_target_ip = '0; rx_dst_ip = '0;
    rx_src_mac = '0; rx_src_ip = '0; udp_src_port = '0; udp_dst_port = '0;
    udp_payload = '0; udp_payload_valid = 0; udp_payload_last = 0;
    frame_done = 0; frame_ok = 0;
  endtask

  task automatic send_arp(input logic [15:0] op, input logic [31:0] tip,
                          input logic [47:0] mac, input logic [31:0] sip);
    is_arp = 1; arp_opcode = op; arp_target_ip = tip;
    rx_src_mac = mac; rx_src_ip = sip;
    frame_done = 1; frame_ok = 1;
    tick();
    clear_in();
  endtask

  task automatic send_udp(input logic [31:0] dip, input logic [15:0] dport,
                          input logic [15:0] sport, input logic [47:0] mac,
                          input logic [31:0] sip, input int n, input logic ok);
    is_ipv4 = 1; is_udp = 1; rx_dst_ip = dip;
    udp_dst_port = dport; udp_src_port = sport;
    rx_src_mac = mac; rx_src_ip = sip;
    for (int i = 0; i < n; i++) begin
      udp_payload = sb[i]; udp_payload_valid = 1; udp_payload_last = (i == n - 1);
      tick();
    end
    udp_payload_valid = 0; udp_payload_last = 0;
    frame_done = 1; frame_ok = ok;
    tick();
    clear_in();
  endtask

  task automatic ack_udp();
    udp_ack = 1;
    tick();
    udp_ack = 0;
  endtask

  task automatic drain(input int n, input bit toggle);
    int k = 0;
    int cyc = 0;
    bit stop = 0;
    while (k < n && cyc < 4 * n + 20 && !stop) begin
      tx_ready = toggle ? cyc[0] : 1'b1;
      chk("tx_valid_in_data", tx_valid, 1);
      if (!tx_valid) begin
        stop = 1;
      end else begin
        chk("tx_data", tx_data, eb[k]);
        chk("tx_last", tx_last, (k == n - 1));
        if (tx_ready) k++;
        tick();
        cyc++;
      end
    end
    tx_ready = 0;
    chk("drain_count", k, n);
    chk("tx_valid_after", tx_valid, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arp_req"}, arp_req, 0);
    chk({tag, "_udp_req"}, udp_req, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_last"}, tx_last, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_len"}, tx_len, 0);
    chk({tag, "_tx_mac"}, tx_dst_mac, 0);
    chk({tag, "_tx_ip"}, tx_dst_ip, 0);
    chk({tag, "_tx_ports"}, {tx_dst_port, tx_src_port, tx_chan}, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    rst_n = 0; arp_ack = 0; udp_ack = 0; tx_ready = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1;
    tick();

    // ARP request for our address: request two cycles after frame_done
    send_arp(16'd1, MY, 48'h021122334455, 32'hC0A80164);
    chk("arp_n1", arp_req, 0);
    tick();
    chk("arp_n2", arp_req, 1);
    chk("arp_mac", tx_dst_mac, 48'h021122334455);
    chk("arp_ip", tx_dst_ip, 32'hC0A80164);
    chk("arp_no_udp", udp_req, 0);
    arp_ack = 1;
    tick();
    arp_ack = 0;
    chk("arp_drop_after_ack", arp_req, 0);

    send_arp(16'd1, 32'hC0A8010B, 48'h021122334455, 32'hC0A80164);
    repeat (3) tick();
    chk("arp_other_ip", arp_req, 0);
    send_arp(16'd2, MY, 48'h021122334455, 32'hC0A80164);
    repeat (3) tick();
    chk("arp_opcode2", arp_req, 0);

    // UDP echo with toggling back-pressure
    sb[0] = 8'hDE; sb[1] = 8'hAD; sb[2] = 8'hBE; sb[3] = 8'hEF; eb = sb;
    send_udp(MY, 16'd5001, 16'd40000, 48'h0A0B0C0D0E0F, 32'hC0A80102, 4, 1);
    chk("udp_n1", udp_req, 0);
    tick();
    chk("udp_req", udp_req, 1);
    chk("udp_len", tx_len, 4);
    chk("udp_chan", tx_chan, 1);
    chk("udp_src_port", tx_src_port, 16'd5001);
    chk("udp_dst_port", tx_dst_port, 16'd40000);
    chk("udp_mac", tx_dst_mac, 48'h0A0B0C0D0E0F);
    chk("udp_ip", tx_dst_ip, 32'hC0A80102);
    ack_udp();
    chk("udp_req_drop", udp_req, 0);
    drain(4, 1);
    chk("drop_after_echo", drop_cnt, 0);

    // non-matching port / IP
    sb[0] = 8'h01; sb[1] = 8'h02;
    send_udp(MY, 16'd5002, 16'd1, 48'h1, 32'h1, 2, 1);
    repeat (3) tick();
    chk("port5002_req", udp_req, 0);
    send_udp(32'hC0A8010B, 16'd5000, 16'd1, 48'h1, 32'h1, 2, 1);
    repeat (3) tick();
    chk("other_ip_req", udp_req, 0);
    chk("nonmatch_drop", drop_cnt, 0);

    // second frame while the first is still streaming
    sb[0] = 8'h11; sb[1] = 8'h22; sb[2] = 8'h33; eb = sb;
    send_udp(MY, 16'd5000, 16'd1234, 48'hAA, 32'hBB, 3, 1);
    tick();
    chk("busyA_req", udp_req, 1);
    chk("busyA_chan", tx_chan, 0);
    chk("busyA_len", tx_len, 3);
    ack_udp();
    sb[0] = 8'h99; sb[1] = 8'h88;
    send_udp(MY, 16'd5001, 16'd77, 48'hCC, 32'hDD, 2, 1);
    chk("busy_drop_cnt", drop_cnt, 1);
    chk("busy_hold_data", tx_data, 8'h11);
    drain(3, 0);
    tick();
    chk("busy_no_req", udp_req, 0);

    // 257 bytes overflow, 256 bytes fits exactly
    for (int i = 0; i < 257; i++) sb[i] = 8'(i) ^ 8'h5A;
    send_udp(MY, 16'd5000, 16'd9, 48'h5, 32'h6, 257, 1);
    chk("ovf_drop_cnt", drop_cnt, 2);
    repeat (3) tick();
    chk("ovf_no_req", udp_req, 0);
    eb = sb;
    send_udp(MY, 16'd5000, 16'd9, 48'h5, 32'h6, 256, 1);
    tick();
    chk("full_req", udp_req, 1);
    chk("full_len", tx_len, 256);
    ack_udp();
    drain(256, 0);

    // bad FCS
    sb[0] = 8'h10;
    send_udp(MY, 16'd5000, 16'd9, 48'h5, 32'h6, 1, 0);
    chk("badfcs_drop_cnt", drop_cnt, 3);
    repeat (3) tick();
    chk("badfcs_no_req", udp_req, 0);

    // ARP and UDP commit in the same cycle: ARP wins
    sb[0] = 8'h77; eb = sb;
    is_ipv4 = 1; is_udp = 1; rx_dst_ip = MY; udp_dst_port = 16'd5001; udp_src_port = 16'd7;
    rx_src_mac = 48'h665544332211; rx_src_ip = 32'hC0A80105;
    udp_payload = 8'h77; udp_payload_valid = 1; udp_payload_last = 1;
    tick();
    udp_payload_valid = 0; udp_payload_last = 0;
    is_arp = 1; arp_opcode = 16'd1; arp_target_ip = MY;
    frame_done = 1; frame_ok = 1;
    tick();
    clear_in();
    chk("both_n1", {arp_req, udp_req}, 2'b00);
    tick();
    chk("both_arp_first", {arp_req, udp_req}, 2'b10);
    chk("both_arp_mac", tx_dst_mac, 48'h665544332211);
    tick();
    chk("both_arp_hold", {arp_req, udp_req}, 2'b10);
    arp_ack = 1;
    tick();
    arp_ack = 0;
    chk("both_gap", {arp_req, udp_req}, 2'b00);
    tick();
    chk("both_udp_next", {arp_req, udp_req}, 2'b01);
    chk("both_udp_len", tx_len, 1);
    ack_udp();
    drain(1, 0);

    // zero-length UDP
    send_udp(MY, 16'd5000, 16'd3, 48'h7, 32'h8, 0, 1);
    tick();
    chk("zero_req", udp_req, 1);
    chk("zero_len", tx_len, 0);
    ack_udp();
    chk("zero_no_valid", {udp_req, tx_valid}, 2'b00);
    tick();
    chk("zero_idle", {udp_req, tx_valid}, 2'b00);

    // buffer freed in the same cycle as a new frame's first byte: new frame dropped
    sb[0] = 8'h42; eb = sb;
    send_udp(MY, 16'd5000, 16'd3, 48'h7, 32'h8, 1, 1);
    tick();
    chk("free_req", udp_req, 1);
    ack_udp();
    chk("free_last_byte", {tx_valid, tx_last, tx_data}, {2'b11, 8'h42});
    is_ipv4 = 1; is_udp = 1; rx_dst_ip = MY; udp_dst_port = 16'd5001;
    udp_payload = 8'h55; udp_payload_valid = 1; udp_payload_last = 1; tx_ready = 1;
    tick();
    tx_ready = 0; udp_payload_valid = 0; udp_payload_last = 0;
    chk("free_done", tx_valid, 0);
    frame_done = 1; frame_ok = 1;
    tick();
    clear_in();
    chk("free_same_cycle_drop", drop_cnt, 4);
    repeat (3) tick();
    chk("free_same_cycle_no_req", udp_req, 0);

    // reset in the middle of a payload stream
    sb[0] = 8'hA1; sb[1] = 8'hB2;
    send_udp(MY, 16'd5001, 16'd3, 48'h7, 32'h8, 2, 1);
    tick();
    ack_udp();
    chk("rst_pre_valid", tx_valid, 1);
    rst_n = 0;
    tick();
    chk_all_zero("mid_rst");
    rst_n = 1;
    repeat (2) tick();
    chk("post_rst_idle", {arp_req, udp_req, tx_valid}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
